// File: rtl/pipe_front_fde.sv
// Front half of a five-stage MIPS pipeline: PC, F/D with register file and next-PC,
// D/E with ALU. Results and forwarding data are presented to the M stage.
module pipe_front_fde (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic [31:0] F_instr,
  input  logic [4:0]  W_A3,
  input  logic [31:0] W_WD,
  input  logic        W_RFWr,
  input  logic [4:0]  M_RFA3,
  input  logic [31:0] M_RFWD,
  input  logic        M_RFWr,
  input  logic        M_Ready,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] E_instr,
  output logic [31:0] E_pc,
  output logic [31:0] E_Y,
  output logic [31:0] E_V2,
  output logic [4:0]  E_RFA3,
  output logic [31:0] E_RFWD,
  output logic        E_RFWr,
  output logic        E_Ready
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_ORI, OP_LUI, OP_LW, OP_SW,
    OP_BEQ, OP_J, OP_JAL, OP_JR
  } op_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ext;
  } de_t;

  function automatic op_e decode(input logic [31:0] instr);
    op_e op;
    op = OP_NOP;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h21:   op = OP_ADDU;
          6'h23:   op = OP_SUBU;
          6'h08:   op = OP_JR;
          default: op = OP_NOP;
        endcase
      end
      6'h0d:   op = OP_ORI;
      6'h0f:   op = OP_LUI;
      6'h23:   op = OP_LW;
      6'h2b:   op = OP_SW;
      6'h04:   op = OP_BEQ;
      6'h02:   op = OP_J;
      6'h03:   op = OP_JAL;
      default: op = OP_NOP;
    endcase
    return op;
  endfunction

  // Two-source forwarding mux; the first source wins, $0 never forwards.
  function automatic logic [31:0] fwd2(
    input logic [4:0]  idx,
    input logic        hi_wr,
    input logic [4:0]  hi_a3,
    input logic [31:0] hi_wd,
    input logic        lo_wr,
    input logic [4:0]  lo_a3,
    input logic [31:0] lo_wd,
    input logic [31:0] base
  );
    if (idx != 5'd0 && hi_wr && hi_a3 == idx) return hi_wd;
    if (idx != 5'd0 && lo_wr && lo_a3 == idx) return lo_wd;
    return base;
  endfunction

  // Readiness of M data is the stall unit's concern; forwarding ignores it.
  logic unused_m_ready;
  assign unused_m_ready = M_Ready;

  logic [31:0] pc_q;
  logic [31:0] fd_instr;
  logic [31:0] fd_pc;
  de_t         de;
  logic [31:0] rf [32];

  logic [31:0] npc;
  op_e         d_op;
  logic [4:0]  d_rs;
  logic [4:0]  d_rt;
  logic [15:0] d_imm;
  logic [31:0] d_sext;
  logic [31:0] d_ext;
  logic [31:0] rs_rf;
  logic [31:0] rt_rf;
  logic [31:0] d_rs_val;
  logic [31:0] d_rt_val;

  assign F_pc    = pc_q;
  assign D_instr = fd_instr;

  // ---------------------------------------------------------------- fetch, F/D
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_q     <= RESET_PC;
      fd_instr <= '0;
      fd_pc    <= '0;
    end else if (!Stall) begin
      pc_q     <= npc;
      fd_instr <= F_instr;
      fd_pc    <= pc_q;
    end
  end

  // ------------------------------------------------------------ register file
  // NOTE: every entry clears on reset, so the file is built from flops with an
  // async clear rather than a RAM; $0 is never written and so stays zero.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (W_RFWr && W_A3 != 5'd0) begin
      rf[W_A3] <= W_WD;
    end
  end

  assign d_op   = decode(fd_instr);
  assign d_rs   = fd_instr[25:21];
  assign d_rt   = fd_instr[20:16];
  assign d_imm  = fd_instr[15:0];
  assign d_sext = {{16{d_imm[15]}}, d_imm};

  // Same-cycle write bypass makes the read transparent to W.
  assign rs_rf = (W_RFWr && W_A3 != 5'd0 && W_A3 == d_rs) ? W_WD : rf[d_rs];
  assign rt_rf = (W_RFWr && W_A3 != 5'd0 && W_A3 == d_rt) ? W_WD : rf[d_rt];

  assign d_rs_val = fwd2(d_rs, E_RFWr, E_RFA3, E_RFWD, M_RFWr, M_RFA3, M_RFWD, rs_rf);
  assign d_rt_val = fwd2(d_rt, E_RFWr, E_RFA3, E_RFWD, M_RFWr, M_RFA3, M_RFWD, rt_rf);

  // NOTE: combinational blocks assign a default first so no path infers a latch.
  always_comb begin
    d_ext = '0;
    case (d_op)
      OP_ORI:              d_ext = {16'h0000, d_imm};
      OP_LUI:              d_ext = {d_imm, 16'h0000};
      OP_LW, OP_SW, OP_BEQ: d_ext = d_sext;
      default:             d_ext = '0;
    endcase
  end

  always_comb begin
    npc = pc_q + 32'd4;
    case (d_op)
      OP_BEQ: begin
        if (d_rs_val == d_rt_val) npc = fd_pc + 32'd4 + {d_sext[29:0], 2'b00};
      end
      OP_J, OP_JAL: npc = {fd_pc[31:28], fd_instr[25:0], 2'b00};
      OP_JR:        npc = d_rs_val;
      default:      npc = pc_q + 32'd4;
    endcase
  end

  // --------------------------------------------------------------------- D/E
  // A stall leaves the instruction in D, so E receives a bubble.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      de <= '0;
    end else if (Stall) begin
      de <= '0;
    end else begin
      de <= '{instr: fd_instr, pc: fd_pc, rd1: d_rs_val, rd2: d_rt_val, ext: d_ext};
    end
  end

  op_e         e_op;
  logic [4:0]  e_rs;
  logic [4:0]  e_rt;
  logic [4:0]  e_rd;
  logic [31:0] e_rs_val;
  logic [31:0] e_rt_val;

  assign e_op     = decode(de.instr);
  assign e_rs     = de.instr[25:21];
  assign e_rt     = de.instr[20:16];
  assign e_rd     = de.instr[15:11];
  assign e_rs_val = fwd2(e_rs, M_RFWr, M_RFA3, M_RFWD, W_RFWr, W_A3, W_WD, de.rd1);
  assign e_rt_val = fwd2(e_rt, M_RFWr, M_RFA3, M_RFWD, W_RFWr, W_A3, W_WD, de.rd2);

  assign E_instr = de.instr;
  assign E_pc    = de.pc;
  assign E_V2    = e_rt_val;
  // Forward data always carries E_Y; consumers trust it only when E_Ready is set.
  assign E_RFWD  = E_Y;

  always_comb begin
    E_Y     = '0;
    E_RFA3  = '0;
    E_RFWr  = 1'b0;
    E_Ready = 1'b0;
    case (e_op)
      OP_ADDU: begin
        E_Y    = e_rs_val + e_rt_val;
        E_RFA3 = e_rd;
        E_RFWr = 1'b1;
      end
      OP_SUBU: begin
        E_Y    = e_rs_val - e_rt_val;
        E_RFA3 = e_rd;
        E_RFWr = 1'b1;
      end
      OP_ORI: begin
        E_Y    = e_rs_val | de.ext;
        E_RFA3 = e_rt;
        E_RFWr = 1'b1;
      end
      OP_LUI: begin
        E_Y     = de.ext;
        E_RFA3  = e_rt;
        E_RFWr  = 1'b1;
        E_Ready = 1'b1;
      end
      OP_LW: begin
        E_Y    = e_rs_val + de.ext;
        E_RFA3 = e_rt;
        E_RFWr = 1'b1;
      end
      OP_SW: begin
        E_Y = e_rs_val + de.ext;
      end
      OP_JAL: begin
        E_Y     = de.pc + 32'd8;
        E_RFA3  = 5'd31;
        E_RFWr  = 1'b1;
        E_Ready = 1'b1;
      end
      default: begin
        E_Y = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_front_fde.sv
// Self-checking bench for pipe_front_fde: directed table, hand-written corner
// sequences, and random stimulus against an instruction-level reference model.
module tb_pipe_front_fde;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Stall;
  logic [31:0] F_instr;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;
  logic        W_RFWr;
  logic [4:0]  M_RFA3;
  logic [31:0] M_RFWD;
  logic        M_RFWr;
  logic        M_Ready;
  logic [31:0] F_pc, D_instr, E_instr, E_pc, E_Y, E_V2, E_RFWD;
  logic [4:0]  E_RFA3;
  logic        E_RFWr, E_Ready;

  pipe_front_fde dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .F_instr(F_instr),
    .W_A3(W_A3), .W_WD(W_WD), .W_RFWr(W_RFWr),
    .M_RFA3(M_RFA3), .M_RFWD(M_RFWD), .M_RFWr(M_RFWr), .M_Ready(M_Ready),
    .F_pc(F_pc), .D_instr(D_instr), .E_instr(E_instr), .E_pc(E_pc),
    .E_Y(E_Y), .E_V2(E_V2), .E_RFA3(E_RFA3), .E_RFWD(E_RFWD),
    .E_RFWr(E_RFWr), .E_Ready(E_Ready)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Small instruction memory at 0x3000; random mode bypasses it.
  logic [31:0] im [16];
  logic        use_im = 1'b1;
  logic [31:0] rnd_instr = '0;
  logic [31:0] im_off;
  always_comb begin
    im_off  = F_pc - 32'h0000_3000;
    F_instr = rnd_instr;
    if (use_im) F_instr = (im_off < 32'd64) ? im[im_off[5:2]] : 32'h0;
  end

  task automatic load_im(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    for (int i = 0; i < 16; i++) im[i] = 32'h0;
    im[0] = a;
    im[1] = b;
    im[2] = c;
  endtask

  task automatic clear_inputs();
    Stall = 1'b0;
    M_RFA3 = '0; M_RFWD = '0; M_RFWr = 1'b0; M_Ready = 1'b0;
    W_A3 = '0;   W_WD = '0;   W_RFWr = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 with reset released.
  task automatic do_reset();
    clear_inputs();
    Rst = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
  endtask

  // Advance one edge and land at the sampling point, mid-cycle.
  task automatic tick();
    @(posedge Clk);
    #4;
  endtask

  // ------------------------------------------------------- reference model
  typedef struct packed {
    logic [31:0] y;
    logic [4:0]  a3;
    logic        wr;
    logic        rdy;
  } eres_t;

  logic [31:0] m_rf [32];
  logic [31:0] m_pc, m_fd_instr, m_fd_pc, m_de_instr, m_de_pc, m_de_rs, m_de_rt;

  function automatic logic [31:0] pick(input logic [4:0] idx,
      input logic w1, input logic [4:0] a1, input logic [31:0] v1,
      input logic w2, input logic [4:0] a2, input logic [31:0] v2,
      input logic [31:0] dflt);
    if (idx == 5'd0) return dflt;
    if (w1 && a1 == idx) return v1;
    if (w2 && a2 == idx) return v2;
    return dflt;
  endfunction

  // What an instruction produces in E given its operand values.
  function automatic eres_t model_exec(input logic [31:0] ins, input logic [31:0] pc,
                                       input logic [31:0] a, input logic [31:0] b);
    logic [5:0]  op   = ins[31:26];
    logic [5:0]  fn   = ins[5:0];
    logic [31:0] zext = {16'h0, ins[15:0]};
    logic [31:0] sext = {{16{ins[15]}}, ins[15:0]};
    eres_t r = '0;
    if (op == 6'h00 && fn == 6'h21)      r = '{a + b, ins[15:11], 1'b1, 1'b0};
    else if (op == 6'h00 && fn == 6'h23) r = '{a - b, ins[15:11], 1'b1, 1'b0};
    else if (op == 6'h0d)                r = '{a | zext, ins[20:16], 1'b1, 1'b0};
    else if (op == 6'h0f)                r = '{{ins[15:0], 16'h0}, ins[20:16], 1'b1, 1'b1};
    else if (op == 6'h23)                r = '{a + sext, ins[20:16], 1'b1, 1'b0};
    else if (op == 6'h2b)                r = '{a + sext, 5'd0, 1'b0, 1'b0};
    else if (op == 6'h03)                r = '{pc + 32'd8, 5'd31, 1'b1, 1'b1};
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pc = 32'h3000; m_fd_instr = '0; m_fd_pc = '0;
    m_de_instr = '0; m_de_pc = '0; m_de_rs = '0; m_de_rt = '0;
  endtask

  // Compare the DUT against the model for this cycle, then advance the model
  // across the coming edge using the inputs now applied.
  task automatic model_cycle(input int cyc);
    eres_t       e;
    logic [31:0] ea, eb, da, db, rfa, rfb, npc;
    logic [4:0]  drs, drt;
    logic [31:0] sext;
    ea = pick(m_de_instr[25:21], M_RFWr, M_RFA3, M_RFWD, W_RFWr, W_A3, W_WD, m_de_rs);
    eb = pick(m_de_instr[20:16], M_RFWr, M_RFA3, M_RFWD, W_RFWr, W_A3, W_WD, m_de_rt);
    e  = model_exec(m_de_instr, m_de_pc, ea, eb);
    check($sformatf("rnd%0d F_pc", cyc), F_pc, m_pc);
    check($sformatf("rnd%0d D_instr", cyc), D_instr, m_fd_instr);
    check($sformatf("rnd%0d E_instr", cyc), E_instr, m_de_instr);
    check($sformatf("rnd%0d E_pc", cyc), E_pc, m_de_pc);
    check($sformatf("rnd%0d E_Y", cyc), E_Y, e.y);
    check($sformatf("rnd%0d E_V2", cyc), E_V2, eb);
    check($sformatf("rnd%0d E_RFA3", cyc), 32'(E_RFA3), 32'(e.a3));
    check($sformatf("rnd%0d E_RFWr", cyc), 32'(E_RFWr), 32'(e.wr));
    check($sformatf("rnd%0d E_Ready", cyc), 32'(E_Ready), 32'(e.rdy));
    if (e.rdy) check($sformatf("rnd%0d E_RFWD", cyc), E_RFWD, e.y);

    drs = m_fd_instr[25:21];
    drt = m_fd_instr[20:16];
    rfa = (W_RFWr && W_A3 != 5'd0 && W_A3 == drs) ? W_WD : m_rf[drs];
    rfb = (W_RFWr && W_A3 != 5'd0 && W_A3 == drt) ? W_WD : m_rf[drt];
    da  = pick(drs, e.wr, e.a3, e.y, M_RFWr, M_RFA3, M_RFWD, rfa);
    db  = pick(drt, e.wr, e.a3, e.y, M_RFWr, M_RFA3, M_RFWD, rfb);
    sext = {{16{m_fd_instr[15]}}, m_fd_instr[15:0]};
    npc  = m_pc + 32'd4;
    if (m_fd_instr[31:26] == 6'h04 && da == db) npc = m_fd_pc + 32'd4 + (sext << 2);
    else if (m_fd_instr[31:26] == 6'h02 || m_fd_instr[31:26] == 6'h03)
      npc = {m_fd_pc[31:28], m_fd_instr[25:0], 2'b00};
    else if (m_fd_instr[31:26] == 6'h00 && m_fd_instr[5:0] == 6'h08) npc = da;

    if (W_RFWr && W_A3 != 5'd0) m_rf[W_A3] = W_WD;
    if (Stall) begin
      m_de_instr = '0; m_de_pc = '0; m_de_rs = '0; m_de_rt = '0;
    end else begin
      m_de_instr = m_fd_instr; m_de_pc = m_fd_pc; m_de_rs = da; m_de_rt = db;
      m_fd_instr = F_instr;    m_fd_pc = m_pc;    m_pc = npc;
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  rs  = 5'($urandom_range(7));
    logic [4:0]  rt  = 5'($urandom_range(7));
    logic [4:0]  rd  = 5'($urandom_range(7));
    logic [15:0] imm = 16'($urandom);
    logic [31:0] ins;
    case ($urandom_range(11))
      0:  ins = {6'h00, rs, rt, rd, 5'h0, 6'h21};
      1:  ins = {6'h00, rs, rt, rd, 5'h0, 6'h23};
      2:  ins = {6'h0d, rs, rt, imm};
      3:  ins = {6'h0f, 5'h0, rt, imm};
      4:  ins = {6'h23, rs, rt, imm};
      5:  ins = {6'h2b, rs, rt, imm};
      6:  ins = {6'h04, rs, rt, imm};
      7:  ins = {6'h02, 26'($urandom)};
      8:  ins = {6'h03, 26'($urandom)};
      9:  ins = {6'h00, rs, 15'h0, 6'h08};
      10: ins = 32'h0;
      default: ins = $urandom;
    endcase
    return ins;
  endfunction

  // ------------------------------------------------------- directed table
  typedef struct packed {
    logic        stall;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    logic        m_wr;
    logic [31:0] pc;
    logic [31:0] d;
    logic [31:0] e_instr;
    logic [31:0] e_y;
    logic [31:0] e_v2;
    logic [4:0]  e_a3;
    logic        e_wr;
    logic        e_rdy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    // ori $1,$0,0x1234 ; addu $2,$1,$1 ; lui $3,0xABCD (stalled one cycle in D)
    tbl[0] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h3000, 32'h0,        32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h3004, 32'h34011234, 32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h3008, 32'h00211021, 32'h34011234, 32'h1234,     32'h0,    5'd1, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 5'd1, 32'h1234, 1'b1, 32'h300C, 32'h3C03ABCD, 32'h00211021, 32'h2468, 32'h1234, 5'd2, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h300C, 32'h3C03ABCD, 32'h0,        32'h0,        32'h0,    5'd0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 32'h3010, 32'h0,        32'h3C03ABCD, 32'hABCD0000, 32'h0,    5'd3, 1'b1, 1'b1};

    clear_inputs();
    @(posedge Clk);
    #1;

    load_im(32'h34011234, 32'h00211021, 32'h3C03ABCD);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge Clk);
        #1;
      end
      Stall = tbl[i].stall;
      M_RFA3 = tbl[i].m_a3; M_RFWD = tbl[i].m_wd;
      M_RFWr = tbl[i].m_wr; M_Ready = tbl[i].m_wr;
      #3;
      check($sformatf("row%0d F_pc", i), F_pc, tbl[i].pc);
      check($sformatf("row%0d D_instr", i), D_instr, tbl[i].d);
      check($sformatf("row%0d E_instr", i), E_instr, tbl[i].e_instr);
      check($sformatf("row%0d E_Y", i), E_Y, tbl[i].e_y);
      check($sformatf("row%0d E_V2", i), E_V2, tbl[i].e_v2);
      check($sformatf("row%0d E_RFA3", i), 32'(E_RFA3), 32'(tbl[i].e_a3));
      check($sformatf("row%0d E_RFWr", i), 32'(E_RFWr), 32'(tbl[i].e_wr));
      check($sformatf("row%0d E_Ready", i), 32'(E_Ready), 32'(tbl[i].e_rdy));
      if (tbl[i].e_rdy) check($sformatf("row%0d E_RFWD", i), E_RFWD, tbl[i].e_y);
    end
    @(posedge Clk);
    #1 clear_inputs();

    // Reset values and taken beq with its delay slot.
    load_im(32'h10000003, 32'h0, 32'h0);
    do_reset();
    #3;
    check("reset F_pc", F_pc, 32'h3000);
    check("reset D_instr", D_instr, 32'h0);
    check("reset E_instr", E_instr, 32'h0);
    check("reset E_RFWr", 32'(E_RFWr), 32'h0);
    check("reset E_Y", E_Y, 32'h0);
    tick();
    check("beq delay slot F_pc", F_pc, 32'h3004);
    tick();
    check("beq target F_pc", F_pc, 32'h3010);

    // jal at 0x3008 to 0x3010, link value 0x3010.
    load_im(32'h0, 32'h0, 32'h0C000C04);
    do_reset();
    tick();
    tick();
    check("jal fetch F_pc", F_pc, 32'h3008);
    tick();
    check("jal slot F_pc", F_pc, 32'h300C);
    tick();
    check("jal target F_pc", F_pc, 32'h3010);
    check("jal E_instr", E_instr, 32'h0C000C04);
    check("jal E_Y", E_Y, 32'h3010);
    check("jal E_RFWD", E_RFWD, 32'h3010);
    check("jal E_RFA3", 32'(E_RFA3), 32'd31);
    check("jal E_Ready", 32'(E_Ready), 32'd1);
    check("jal E_RFWr", 32'(E_RFWr), 32'd1);
    tick();
    check("after jal F_pc", F_pc, 32'h3014);

    // W write bypassed into D, write to $0 ignored, stored value read back.
    load_im(32'h00A03021, 32'h34070001, 32'h00A54021);
    do_reset();
    @(posedge Clk);
    #1 W_RFWr = 1'b1; W_A3 = 5'd5; W_WD = 32'hDEADBEEF;
    @(posedge Clk);
    #1 W_RFWr = 1'b1; W_A3 = 5'd0; W_WD = 32'hFFFFFFFF;
    #3;
    check("rf bypass E_Y", E_Y, 32'hDEADBEEF);
    check("rf bypass E_RFA3", 32'(E_RFA3), 32'd6);
    @(posedge Clk);
    #1 clear_inputs();
    #3;
    check("r0 write E_Y", E_Y, 32'h00000001);
    check("r0 write E_RFA3", 32'(E_RFA3), 32'd7);
    tick();
    check("rf stored E_Y", E_Y, 32'hBD5B7DDE);
    check("rf stored E_RFA3", 32'(E_RFA3), 32'd8);

    // Random stimulus against the model.
    @(posedge Clk);
    #1 use_im = 1'b0;
    rnd_instr = rand_instr();
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) begin
        @(posedge Clk);
        #1;
      end
      rnd_instr = rand_instr();
      Stall   = ($urandom_range(4) == 0);
      M_RFA3  = 5'($urandom_range(7));
      M_RFWD  = $urandom;
      M_RFWr  = 1'($urandom);
      M_Ready = 1'($urandom);
      W_A3    = 5'($urandom_range(7));
      W_WD    = $urandom;
      W_RFWr  = 1'($urandom);
      #3;
      model_cycle(c);
    end

    // Asynchronous reset takes effect without a clock edge.
    Rst = 1'b0;
    #1;
    check("async reset F_pc", F_pc, 32'h3000);
    check("async reset D_instr", D_instr, 32'h0);
    check("async reset E_instr", E_instr, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_front_fde.md
# pipe_front_fde

Front half of the five-stage MIPS pipeline: instruction fetch (PC), the F/D register with register file, immediate extension and next-PC logic, and the D/E register with ALU. It receives M- and W-stage writeback and forwarding signals from the rest of the core and a stall from the stall unit. It presents the E-stage results to the M stage.

## Interface
No parameters.
- Clk  in  1  system clock, rising edge
- Rst  in  1  reset, asynchronous, active-low
- Stall  in  1  from stall unit; freezes PC and F/D, bubbles D/E
- F_instr  in  32  instruction word at F_pc, from external IM, combinational
- W_A3  in  5  RF write address; also the W forwarding source
- W_WD  in  32  RF write data
- W_RFWr  in  1  RF write enable
- M_RFA3  in  5  M-stage destination register
- M_RFWD  in  32  M-stage forward data
- M_RFWr  in  1  M-stage writes RF
- M_Ready  in  1  M_RFWD valid
- F_pc  out  32  current PC (IM address)
- D_instr  out  32  F/D instruction, to stall unit
- E_instr, E_pc  out  32  D/E instruction and PC
- E_Y  out  32  ALU result, or E_pc+8 for jal
- E_V2  out  32  forwarded rt value (store data)
- E_RFA3  out  5  E destination register, 0 if no write
- E_RFWD  out  32  E forward data
- E_RFWr  out  1  E instruction writes RF
- E_Ready  out  1  E_RFWD valid

## Operation
- Supported instructions: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, and nop (0x00000000). Any other encoding behaves as nop.
- Fetch:
  - PC resets to 0x00003000.
  - PC loads NPC on each edge unless Stall is high.
  - There is one branch delay slot.
- Next-PC (D stage, combinational):
  - beq with equal forwarded operands: D_pc+4+(sext(imm)<<2).
  - j and jal: {D_pc[31:28], idx, 2'b00}.
  - jr: forwarded rs.
  - Otherwise: F_pc+4.
- Register file:
  - 32×32; $0 reads as 0.
  - Write on rising edge when W_RFWr is high and W_A3 is not 0.
  - Read is bypassed: a same-cycle write to the read address returns W_WD.
- D forwarding (per operand):
  - Forward only when the register index is not 0, the source RFWr is high, and the source A3 equals the index.
  - Priority: E over M over RF.
  - An unready match still forwards; correctness is the stall unit's responsibility.
- EXT:
  - ori: zero-extended imm.
  - lw, sw, beq: sign-extended imm.
  - lui: imm<<16.
- E forwarding operands: rs and rt are re-forwarded with priority M over W (W_A3/W_WD/W_RFWr) over the latched values.
- ALU:
  - addu: rs+rt. subu: rs−rt. ori: rs|EXT. lui: EXT. lw/sw: rs+EXT.
  - All arithmetic mod 2^32; no overflow trap.
- Destination register:
  - addu, subu: rd.
  - ori, lui, lw: rt.
  - jal: 31.
  - Otherwise 0, with RFWr low.
- E forwarding output:
  - jal: E_RFWD=E_pc+8, E_Ready=1.
  - lui: E_RFWD=EXT, E_Ready=1.
  - Otherwise E_Ready=0.

## Timing
- Rst low, asynchronous: PC=0x00003000; F/D, D/E and all RF entries are 0. All E outputs read 0 and D_instr reads 0.
- F/D latches F_instr and F_pc when Stall is low; it holds when Stall is high.
- D/E latches D_instr, D_pc, forwarded RD1/RD2 and EXT every edge.
  - When Stall is high, D/E clears synchronously to all-zero (nop, pc 0).
- Latency:
  - An instruction fetched at edge n is in D after edge n+1 and in E after edge n+2.
  - E_* outputs are combinational from the D/E register and the M/W forwarding inputs.
- The branch decision uses current-cycle forwarded values with no extra cycle. Stall has priority over the branch: PC holds.

## Test plan
- Reset: hold Rst=0 for 2 cycles, then release → F_pc=0x00003000, E_instr=0, E_RFWr=0; next edge F_pc=0x00003004.
- Forwarding:
  - Program: ori $1,$0,0x1234 (0x34011234), then addu $2,$1,$1 (0x00211021).
  - When addu reaches E, drive M_RFA3=1, M_RFWD=0x1234, M_RFWr=1, M_Ready=1 → E_Y=0x00002468, E_RFA3=2.
- beq taken: 0x10000003 at 0x3000 → F_pc sequence 0x3000, 0x3004 (delay slot), 0x3010.
- jal:
  - 0x0C000C04 at 0x3008 → F_pc 0x300C, then 0x3010.
  - In E: E_Y=E_RFWD=0x00003010, E_RFA3=31, E_Ready=1.
- Stall: assert Stall for 1 cycle with lui $3,0xABCD in D → F_pc and D_instr hold; E_instr=0. After release, E_Y=0xABCD0000 and E_Ready=1.
- RF write:
  - W_RFWr=1, W_A3=5, W_WD=0xDEADBEEF while addu reading $5 is in D → value 0xDEADBEEF reaches E.
  - A write to $0 leaves reads of $0 at 0.
